// File: rtl/wb2apb_timeout_bridge.sv
// Wishbone-classic slave to APB3 master bridge with a bounded PREADY wait.
// Optional macro WB2APB_ERR_EN adds wbs_err_o for timeouts and PSLVERR.
module wb2apb_timeout_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
`ifdef WB2APB_ERR_EN
  output logic        wbs_err_o,
`endif
  output logic [31:0] m_apb_addr,
  output logic        m_apb_sel,
  output logic        m_apb_ena,
  output logic        m_apb_write,
  output logic [31:0] m_apb_wdata,
  output logic [3:0]  m_apb_pstb,
  input  logic [31:0] m_apb_rdata,
  input  logic        m_apb_rready,
  input  logic        m_apb_slverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // With the timeout disabled the counter simply parks at all-ones.
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? {CNT_W{1'b1}} : CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             abort;
  logic             timed_out;
  logic [31:0]      rdata_q;
  logic             req;
  logic             tmo_hit;

`ifdef WB2APB_ERR_EN
  logic             slverr_q;
`else
  logic             unused_slverr;
  assign unused_slverr = m_apb_slverr;
`endif

  assign req     = wbs_cyc_i & wbs_stb_i;
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST) && !m_apb_rready;

  assign m_apb_sel = (state == SETUP) || (state == ACCESS);
  assign m_apb_ena = (state == ACCESS);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (m_apb_rready || tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      abort       <= 1'b0;
      timed_out   <= 1'b0;
      rdata_q     <= '0;
      m_apb_addr  <= '0;
      m_apb_write <= 1'b0;
      m_apb_wdata <= '0;
      m_apb_pstb  <= '0;
`ifdef WB2APB_ERR_EN
      slverr_q    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req) begin
            m_apb_addr  <= wbs_adr_i;
            m_apb_write <= wbs_we_i;
            m_apb_wdata <= wbs_dat_i;
            m_apb_pstb  <= wbs_we_i ? wbs_sel_i : 4'b0000;
            abort       <= 1'b0;
            timed_out   <= 1'b0;
            rdata_q     <= '0;
            cnt         <= '0;
`ifdef WB2APB_ERR_EN
            slverr_q    <= 1'b0;
`endif
          end
        end
        SETUP: begin
          if (!wbs_cyc_i) abort <= 1'b1;
        end
        ACCESS: begin
          if (!wbs_cyc_i) abort <= 1'b1;
          if (m_apb_rready) begin
            rdata_q  <= m_apb_rdata;
`ifdef WB2APB_ERR_EN
            slverr_q <= m_apb_slverr;
`endif
          end else if (tmo_hit) begin
            timed_out <= 1'b1;
          end else if (cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // An aborted Wishbone cycle gets neither ack nor err.
  always_comb begin
    wbs_ack_o = 1'b0;
    wbs_dat_o = '0;
`ifdef WB2APB_ERR_EN
    wbs_err_o = 1'b0;
    if (state == RESP && !abort) begin
      if (timed_out || slverr_q) begin
        wbs_err_o = 1'b1;
      end else begin
        wbs_ack_o = 1'b1;
        if (!m_apb_write) wbs_dat_o = rdata_q;
      end
    end
`else
    if (state == RESP && !abort) begin
      wbs_ack_o = 1'b1;
      if (!m_apb_write) wbs_dat_o = timed_out ? TIMEOUT_RDATA : rdata_q;
    end
`endif
  end

endmodule

// File: tb/tb_wb2apb_timeout_bridge.sv
// Directed bench for wb2apb_timeout_bridge (TIMEOUT_CYCLES=8); honours WB2APB_ERR_EN.
module tb_wb2apb_timeout_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] adr = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        err_w;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata = '0;
  logic        pready = 1'b1;
  logic        pslverr = 1'b0;

  int checks = 0;
  int errors = 0;
  int lat;

  wb2apb_timeout_bridge #(.TIMEOUT_CYCLES(8), .TIMEOUT_RDATA(32'hDEAD_BEEF), .CNT_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat_i), .wbs_adr_i(adr),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
`ifdef WB2APB_ERR_EN
    .wbs_err_o(err_w),
`endif
    .m_apb_addr(paddr), .m_apb_sel(psel), .m_apb_ena(penable),
    .m_apb_write(pwrite), .m_apb_wdata(pwdata), .m_apb_pstb(pstrb),
    .m_apb_rdata(prdata), .m_apb_rready(pready), .m_apb_slverr(pslverr)
  );

`ifndef WB2APB_ERR_EN
  assign err_w = 1'b0;
`endif

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
  endtask

  task automatic end_req;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wait_resp(input int max, output int n);
    n = 0;
    while (n < max) begin
      tick;
      n++;
      if (wbs_ack_o || err_w) break;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
    chk("rst_dat", wbs_dat_o, 32'd0);
    chk("rst_psel", {31'd0, psel}, 32'd0);
    chk("rst_pena", {31'd0, penable}, 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_pstrb", {28'd0, pstrb}, 32'd0);
`ifdef WB2APB_ERR_EN
    chk("rst_err", {31'd0, err_w}, 32'd0);
`endif
    tick;
    rst = 1'b0;
    tick;

    // Zero-wait write
    pready = 1'b1; prdata = 32'h1111_2222;
    start_req(1'b1, 32'h3000_0204, 32'h0000_00A5, 4'hF);
    tick;
    chk("w_setup_sel", {31'd0, psel}, 32'd1);
    chk("w_setup_ena", {31'd0, penable}, 32'd0);
    chk("w_paddr", paddr, 32'h3000_0204);
    chk("w_pwdata", pwdata, 32'h0000_00A5);
    chk("w_pstrb", {28'd0, pstrb}, 32'hF);
    chk("w_pwrite", {31'd0, pwrite}, 32'd1);
    tick;
    chk("w_access_ena", {31'd0, penable}, 32'd1);
    chk("w_access_ack", {31'd0, wbs_ack_o}, 32'd0);
    tick;
    chk("w_resp_ack", {31'd0, wbs_ack_o}, 32'd1);
    chk("w_resp_dat", wbs_dat_o, 32'd0);
    chk("w_resp_psel", {31'd0, psel}, 32'd0);
    tick;
    end_req;
    chk("w_ack_one_cycle", {31'd0, wbs_ack_o}, 32'd0);
    tick;

    // Wait-state read: PREADY low for 4 ACCESS cycles
    pready = 1'b0;
    start_req(1'b0, 32'h3000_0100, 32'h5555_5555, 4'h3);
    lat = 0;
    tick; lat++;
    chk("r_pstrb_read", {28'd0, pstrb}, 32'h0);
    tick; lat++;
    for (int i = 0; i < 4; i++) begin
      chk("r_wait_ena", {31'd0, penable}, 32'd1);
      chk("r_wait_addr", paddr, 32'h3000_0100);
      tick; lat++;
    end
    chk("r_still_access", {31'd0, penable}, 32'd1);
    pready = 1'b1; prdata = 32'h1234_5678;
    tick; lat++;
    chk("r_latency", lat, 32'd7);
    chk("r_ack", {31'd0, wbs_ack_o}, 32'd1);
    chk("r_dat", wbs_dat_o, 32'h1234_5678);
    tick;
    end_req;
    chk("r_dat_cleared", wbs_dat_o, 32'd0);
    tick;

    // Timeout read: PREADY held low, 8 ACCESS cycles
    pready = 1'b0; prdata = 32'h0;
    start_req(1'b0, 32'h3000_0300, 32'h0, 4'hF);
    tick;
    tick;
    for (int i = 0; i < 8; i++) begin
      chk("t_psel_held", {31'd0, psel}, 32'd1);
      tick;
    end
    chk("t_psel_dropped", {31'd0, psel}, 32'd0);
`ifdef WB2APB_ERR_EN
    chk("t_err", {31'd0, err_w}, 32'd1);
    chk("t_ack", {31'd0, wbs_ack_o}, 32'd0);
    chk("t_dat", wbs_dat_o, 32'd0);
`else
    chk("t_ack", {31'd0, wbs_ack_o}, 32'd1);
    chk("t_dat", wbs_dat_o, 32'hDEAD_BEEF);
`endif
    tick;
    end_req;
    pready = 1'b1;
    tick;

    // PSLVERR on a read
    pslverr = 1'b1; prdata = 32'hCAFE_0001;
    start_req(1'b0, 32'h3000_0400, 32'h0, 4'hF);
    wait_resp(20, lat);
    chk("e_latency", lat, 32'd3);
`ifdef WB2APB_ERR_EN
    chk("e_err", {31'd0, err_w}, 32'd1);
    chk("e_ack", {31'd0, wbs_ack_o}, 32'd0);
`else
    chk("e_ack", {31'd0, wbs_ack_o}, 32'd1);
    chk("e_dat", wbs_dat_o, 32'hCAFE_0001);
`endif
    tick;
    end_req;
    pslverr = 1'b0;
    tick;

    // Wishbone cycle dropped during ACCESS
    pready = 1'b0;
    start_req(1'b1, 32'h3000_0500, 32'h0000_0077, 4'h1);
    tick;
    tick;
    end_req;
    tick;
    chk("a_apb_continues", {31'd0, penable}, 32'd1);
    pready = 1'b1;
    tick;
    chk("a_resp_psel", {31'd0, psel}, 32'd0);
    chk("a_no_ack", {31'd0, wbs_ack_o}, 32'd0);
    chk("a_no_err", {31'd0, err_w}, 32'd0);
    tick;
    prdata = 32'h0000_5555;
    start_req(1'b0, 32'h3000_0600, 32'h0, 4'hF);
    wait_resp(20, lat);
    chk("a_next_latency", lat, 32'd3);
    chk("a_next_dat", wbs_dat_o, 32'h0000_5555);
    tick;
    end_req;
    tick;

    // Reset asserted mid-ACCESS
    pready = 1'b0;
    start_req(1'b0, 32'h3000_0700, 32'h0, 4'hF);
    tick;
    tick;
    chk("x_pre_psel", {31'd0, psel}, 32'd1);
    rst = 1'b1;
    #1;
    chk("x_psel", {31'd0, psel}, 32'd0);
    chk("x_pena", {31'd0, penable}, 32'd0);
    chk("x_ack", {31'd0, wbs_ack_o}, 32'd0);
    chk("x_paddr", paddr, 32'd0);
    end_req;
    tick;
    rst = 1'b0;
    tick;
    pready = 1'b1; prdata = 32'h0BAD_F00D;
    start_req(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    wait_resp(20, lat);
    chk("x_after_latency", lat, 32'd3);
    chk("x_after_dat", wbs_dat_o, 32'h0BAD_F00D);
    chk("x_after_paddr", paddr, 32'h3000_0000);
    tick;
    end_req;
    tick;

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb2apb_timeout_bridge.md
Name: wb2apb_timeout_bridge

Overview:
Wishbone-classic slave to APB3 master bridge. It sits between the Caravel Wishbone port and the APB crossbar that fans out to the i2c, pwm, gpio, timer, dirctrl and jtag peripherals. It issues one APB transfer per Wishbone cycle and registers the response back to Wishbone. A bounded PREADY wait stops a hung peripheral from stalling the Wishbone bus.

Parameters:
- TIMEOUT_CYCLES, 255: maximum ACCESS-phase cycles with PREADY low before the transfer is abandoned; 0 disables the timeout (wait forever).
- TIMEOUT_RDATA, 32'hDEAD_BEEF: value returned on wbs_dat_o for a timed-out read.
- CNT_W, 16: width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
- wb_clk_i  in  1  single clock for both sides
- wb_rst_i  in  1  reset, asynchronous, active-high
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  1 = write
- wbs_sel_i  in  4  byte selects
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  byte address
- wbs_ack_o  out  1  one-cycle acknowledge
- wbs_dat_o  out  32  read data, valid while wbs_ack_o=1
- wbs_err_o  out  1  error strobe (present only with WB2APB_ERR_EN)
- m_apb_addr  out  32  PADDR
- m_apb_sel  out  1  PSEL
- m_apb_ena  out  1  PENABLE
- m_apb_write  out  1  PWRITE
- m_apb_wdata  out  32  PWDATA
- m_apb_pstb  out  4  PSTRB
- m_apb_rdata  in  32  PRDATA
- m_apb_rready  in  1  PREADY
- m_apb_slverr  in  1  PSLVERR

Behaviour:
- Reset values (wb_rst_i high, asynchronous): all outputs 0, state IDLE, counter 0, abort flag 0. A reset mid-transfer drops PSEL/PENABLE immediately. No ack is issued for the interrupted cycle.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: if wbs_cyc_i & wbs_stb_i at a clock edge, latch the following and go to SETUP:
  - adr → m_apb_addr
  - we → m_apb_write
  - dat_i → m_apb_wdata
  - pstb = we ? sel : 4'b0000
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Address, data, write and strobe stay stable.
  - PREADY=1 at an edge: capture PRDATA and PSLVERR, go to RESP, clear PSEL/PENABLE.
  - PREADY=0: counter increments.
  - Timeout: if TIMEOUT_CYCLES≠0 and counter reaches TIMEOUT_CYCLES-1 with PREADY still 0, go to RESP with the timeout flag set. PSEL/PENABLE drop and the APB transfer is abandoned.
- RESP: one cycle, then IDLE; counter cleared.
  - wbs_ack_o=1.
  - wbs_dat_o = captured PRDATA for reads, TIMEOUT_RDATA for a timed-out read, 0 for writes.
  - wbs_dat_o returns to 0 after RESP.
- Latency with zero-wait peripheral: request sampled at edge 0, ack high during cycle after edge 2 (3 cycles request→ack). Each PREADY-low cycle adds 1.
- Back-to-back: IDLE re-samples stb on the edge after RESP. No new request is taken during SETUP/ACCESS/RESP.
- Cycle abort: if wbs_cyc_i falls during SETUP/ACCESS, the APB transfer still completes (APB is not abortable) but the abort flag suppresses ack/err in RESP.
- PSLVERR=1 without WB2APB_ERR_EN: ignored; normal ack with PRDATA.
- Counter saturates at TIMEOUT_CYCLES-1 and never wraps.

Optional Feature:
- Macro WB2APB_ERR_EN.
- Defined: port wbs_err_o exists. In RESP, a timeout or captured PSLVERR=1 asserts wbs_err_o=1 for one cycle instead of wbs_ack_o (ack stays 0), and wbs_dat_o=0. Reset value 0.
- Undefined: no wbs_err_o port. Timeouts and slave errors complete with wbs_ack_o=1 as described above.

Test Plan:
- Zero-wait write: adr=0x3000_0204, dat=0x0000_00A5, sel=4'hF, we=1 → PSEL one cycle before PENABLE; PWDATA=0xA5, PSTRB=F; ack 3 cycles after request for exactly 1 cycle; wbs_dat_o=0.
- Wait-state read: PREADY low 4 cycles, PRDATA=0x1234_5678 → ack 7 cycles after request; wbs_dat_o=0x1234_5678; address stable throughout ACCESS.
- Timeout with TIMEOUT_CYCLES=8 and PREADY held 0, read → PSEL drops after 8 ACCESS cycles; ack with wbs_dat_o=0xDEAD_BEEF (err=1, ack=0 with WB2APB_ERR_EN).
- PSLVERR=1 on a read → without macro ack=1 with PRDATA; with macro err=1, ack=0.
- wbs_cyc_i dropped during ACCESS → APB completes on PREADY; no ack/err; next request is accepted normally.
- wb_rst_i asserted mid-ACCESS → PSEL, PENABLE, ack cleared asynchronously; after release, a read of 0x3000_0000 completes in 3 cycles.
